// File: rtl/modulo_arbitro_comparador_pkg.sv
// Shared definitions for controllers that time-share one magnitude comparator:
// operand width, state encoding and the two-requester round-robin pick.
package modulo_arbitro_comparador_pkg;

    localparam int WIDTH = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_COMPARE = ST_COMPARE,
        S_ACK     = ST_ACK
    } state_t;

    // With both requesters active the one not served last wins; otherwise the lone requester.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/modulo_comparador7bits.sv
// Combinational magnitude comparator shared between requesters; exactly one
// of the three outputs is high for any operand pair.
module modulo_comparador7bits
    import modulo_arbitro_comparador_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b
);

    always_comb begin
        a_lt_b = (a < b);
        a_eq_b = (a == b);
        a_gt_b = (a > b);
    end

endmodule

// File: rtl/modulo_arbitro_comparador.sv
// Round-robin arbiter/sequencer in front of a single shared comparator:
// grant, latch operands, compare, then return a registered result with a one-cycle ack.
module modulo_arbitro_comparador
    import modulo_arbitro_comparador_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             req1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic             ack0,
    output logic             ack1,
    output logic             AltB,
    output logic             AeqB,
    output logic             AgtB,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             altb_q, altb_d;
    logic             aeqb_q, aeqb_d;
    logic             agtb_q, agtb_d;
    logic             busy_q, busy_d;
    logic             winner;
    logic             cmp_lt, cmp_eq, cmp_gt;

    modulo_comparador7bits u_comparador (
        .a      (op_a_q),
        .b      (op_b_q),
        .a_lt_b (cmp_lt),
        .a_eq_b (cmp_eq),
        .a_gt_b (cmp_gt)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        altb_d       = altb_q;
        aeqb_d       = aeqb_q;
        agtb_d       = agtb_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = 1'b0;
        winner       = pick_winner(req0, req1, last_grant_q);

        case (state_q)
            S_IDLE: begin
                // Operands are captured only here, so later input changes cannot disturb the compare.
                if (req0 || req1) begin
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    op_a_d       = winner ? A1 : A0;
                    op_b_d       = winner ? B1 : B0;
                    state_d      = S_COMPARE;
                    busy_d       = 1'b1;
                end
            end
            S_COMPARE: begin
                altb_d  = cmp_lt;
                aeqb_d  = cmp_eq;
                agtb_d  = cmp_gt;
                ack0_d  = ~grant_id_q;
                ack1_d  = grant_id_q;
                state_d = S_ACK;
                busy_d  = 1'b1;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset starts with last_grant = 1 so requester 0 is favoured on the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            altb_q       <= 1'b0;
            aeqb_q       <= 1'b0;
            agtb_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            altb_q       <= altb_d;
            aeqb_q       <= aeqb_d;
            agtb_q       <= agtb_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign AltB = altb_q;
    assign AeqB = aeqb_q;
    assign AgtB = agtb_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_modulo_arbitro_comparador.sv
// Self-checking bench for modulo_arbitro_comparador: a timeline model of grants
// checked every cycle, plus directed scenarios with hand-derived expectations.
module tb_modulo_arbitro_comparador;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [4:0] A0, B0, A1, B1;
    logic       ack0, ack1, AltB, AeqB, AgtB, busy;

    int checks = 0;
    int fails  = 0;

    modulo_arbitro_comparador dut (
        .clk  (clk),
        .reset(reset),
        .req0 (req0),
        .A0   (A0),
        .B0   (B0),
        .req1 (req1),
        .A1   (A1),
        .B1   (B1),
        .ack0 (ack0),
        .ack1 (ack1),
        .AltB (AltB),
        .AeqB (AeqB),
        .AgtB (AgtB),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Timeline model: a grant on edge g yields busy after edges g and g+1,
    // ack and result after edge g+1, and the next grant no earlier than edge g+3.
    int         cyc, g_edge, next_ok;
    logic       m_id, m_last;
    logic [2:0] m_pend, m_res;
    logic       m_ack0, m_ack1, m_busy;
    logic [4:0] ma, mb;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                cyc = 0; next_ok = 1; g_edge = -100; m_last = 1'b1; m_id = 1'b0;
                m_res = 3'b000; m_pend = 3'b000;
                m_ack0 = 1'b0; m_ack1 = 1'b0; m_busy = 1'b0;
            end else begin
                cyc++;
                if (cyc >= next_ok && (req0 || req1)) begin
                    m_id   = (req0 && req1) ? ~m_last : req1;
                    m_last = m_id;
                    ma     = m_id ? A1 : A0;
                    mb     = m_id ? B1 : B0;
                    m_pend = {ma < mb, ma == mb, ma > mb};
                    g_edge  = cyc;
                    next_ok = cyc + 3;
                end
                m_busy = (cyc == g_edge) || (cyc == g_edge + 1);
                m_ack0 = (cyc == g_edge + 1) && !m_id;
                m_ack1 = (cyc == g_edge + 1) && m_id;
                if (cyc == g_edge + 1) m_res = m_pend;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                checkOutput("model_ack0", ack0, m_ack0);
                checkOutput("model_ack1", ack1, m_ack1);
                checkOutput("model_AltB", AltB, m_res[2]);
                checkOutput("model_AeqB", AeqB, m_res[1]);
                checkOutput("model_AgtB", AgtB, m_res[0]);
                checkOutput("model_busy", busy, m_busy);
                checkOutput("model_ack_exclusive", ack0 & ack1, 1'b0);
            end
        end
    end

    task automatic applyStimulus(input logic r0, input logic [4:0] a0, input logic [4:0] b0,
                                 input logic r1, input logic [4:0] a1, input logic [4:0] b1);
        @(negedge clk);
        #1;
        req0 = r0; A0 = a0; B0 = b0;
        req1 = r1; A1 = a1; B1 = b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack0"}, ack0, 1'b0);
        checkOutput({tag, "_ack1"}, ack1, 1'b0);
        checkOutput({tag, "_AltB"}, AltB, 1'b0);
        checkOutput({tag, "_AeqB"}, AeqB, 1'b0);
        checkOutput({tag, "_AgtB"}, AgtB, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic checkResult(input string tag, input logic e0, input logic e1,
                               input logic lt, input logic eq, input logic gt);
        checkOutput({tag, "_ack0"}, ack0, e0);
        checkOutput({tag, "_ack1"}, ack1, e1);
        checkOutput({tag, "_AltB"}, AltB, lt);
        checkOutput({tag, "_AeqB"}, AeqB, eq);
        checkOutput({tag, "_AgtB"}, AgtB, gt);
    endtask

    // Counts negedges until ack0 is seen, up to a bound; -1 when it never arrives.
    task automatic waitAck0(input int max_cycles, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (ack0 === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; A0 = 0; B0 = 0; A1 = 0; B1 = 0;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Single request from requester 0: 12 vs 7 is greater-than
        applyStimulus(1, 5'd12, 5'd7, 0, 0, 0);
        applyStimulus(0, 5'd12, 5'd7, 0, 0, 0);
        @(negedge clk); #1;
        checkResult("t1", 1, 0, 0, 0, 1);
        repeat (2) @(negedge clk);

        // Requester 1 alone: equal, then less-than
        applyStimulus(0, 0, 0, 1, 5'd3, 5'd3);
        applyStimulus(0, 0, 0, 0, 5'd3, 5'd3);
        @(negedge clk); #1;
        checkResult("t2eq", 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd31);
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd31);
        @(negedge clk); #1;
        checkResult("t2lt", 0, 1, 1, 0, 0);
        repeat (2) @(negedge clk);

        // Both held from reset: acks alternate 0,1,0,1 every 3 cycles, results gt,lt
        #1;
        reset = 1'b1;
        req0 = 1; A0 = 5'd9; B0 = 5'd4;
        req1 = 1; A1 = 5'd2; B1 = 5'd20;
        @(negedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("both_busy_%0d", i), busy, (i % 3) != 0);
            if (i == 2 || i == 8) checkResult($sformatf("both_%0d", i), 1, 0, 0, 0, 1);
            if (i == 5 || i == 11) checkResult($sformatf("both_%0d", i), 0, 1, 1, 0, 0);
        end
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // Operands latched at grant: later A0 change and req drop are ignored
        applyStimulus(1, 5'd1, 5'd30, 0, 0, 0);
        applyStimulus(0, 5'd31, 5'd30, 0, 0, 0);
        @(negedge clk); #1;
        checkResult("latch", 1, 0, 1, 0, 0);
        repeat (2) @(negedge clk);

        // Reset during COMPARE aborts; afterwards requester 0 wins contention
        applyStimulus(1, 5'd20, 5'd10, 1, 5'd4, 5'd6);
        @(negedge clk); #1;
        checkOutput("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkAllZero("abort");
        @(negedge clk); #1;
        checkAllZero("abort_hold");
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checkResult("after_reset", 1, 0, 0, 0, 1);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // Holding req0 through ack0 starts another transaction straight away
        applyStimulus(1, 5'd4, 5'd4, 0, 0, 0);
        waitAck0(6, n);
        checks++;
        if (n != 2) begin
            fails++;
            $display("[TB] FAIL hold_first_latency: got %0d cycles, expected 2", n);
        end
        waitAck0(6, n);
        req0 = 0;
        checks++;
        if (n != 3) begin
            fails++;
            $display("[TB] FAIL hold_repeat_latency: got %0d cycles, expected 3", n);
        end
        checkResult("hold", 1, 0, 0, 1, 0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
